rf_2p_fifo_ctrl: RTL
====================

// Module: rf_2p_fifo_ctrl
// PURPOSE
//  FIFO controller in front of one RF_2P register-file macro (SIZE lanes sharing one address).
//  Accepts a valid/ready word stream, writes it into the RF and issues RF reads.
//  Absorbs the RF's 1-cycle read latency with a 2-entry output skid buffer and returns words in order at full rate.
//  Sits between a PE input stage and its RF_2P instance.
// PARAMETERS
//  WORDWD  12               RF depth in words; need not be a power of 2
//  DWD     16               data width per lane
//  AWD     $clog2(WORDWD)   RF address width
//  SIZE    1                lanes (RF instances) driven in lockstep
//  CWD     $clog2(WORDWD+3) occupancy counter width
// PORTS
//  i_clk       in   1         clock, rising edge
//  i_rst       in   1         asynchronous, active-high reset
//  i_clear     in   1         synchronous flush
//  i_dval      in   1         input word valid
//  o_drdy      out  1         input ready
//  i_data      in   DWD[SIZE] input word, one per lane
//  o_dval      out  1         output word valid
//  i_drdy      in   1         downstream ready
//  o_data      out  DWD[SIZE] output word (skid head)
//  o_count     out  CWD       words held: RF-resident + in-flight + skid
//  o_rf_read   out  1         RF read enable (RF_2P i_read)
//  o_rf_write  out  1         RF write enable (RF_2P i_write)
//  o_rf_raddr  out  AWD       RF read address
//  o_rf_waddr  out  AWD       RF write address
//  o_rf_wdata  out  DWD[SIZE] RF write data; equals i_data
//  i_rf_rdata  in   DWD[SIZE] RF read data; valid the cycle after o_rf_read
// BEHAVIOUR
//  Reset state, async on i_rst: wptr=rptr=0, rf_cnt=0, inflight=0, skid_cnt=0.
//  Outputs while i_rst is high: o_dval=0, o_count=0, o_rf_read=0, o_rf_write=0, o_data=0, o_drdy=1.
//  Handshake: push = i_dval&o_drdy; pop = o_dval&i_drdy. i_dval must not depend on o_drdy.
//   Once o_dval=1, it and o_data hold until pop.
//  Write: o_rf_write = push & !i_clear; o_rf_waddr = wptr.
//   wptr advances by 1 per write and wraps WORDWD-1 -> 0.
//  o_drdy = (rf_cnt != WORDWD). It is a function of registered state only; no path from i_drdy.
//  Read issue: o_rf_read = (rf_cnt != 0) & (skid_cnt + inflight - pop < 2) & !i_clear; o_rf_raddr = rptr.
//   rptr wraps like wptr. A word written at cycle t is readable no earlier than t+1, so same-slot
//   read/write collision cannot occur.
//  inflight <= o_rf_read. When inflight=1, i_rf_rdata enters the skid tail in the same edge.
//   A pop in that cycle frees the head normally.
//  rf_cnt <= rf_cnt + write - read. skid_cnt <= skid_cnt + inflight - pop (0..2).
//  Latency: word accepted at cycle t -> RF read at t+1 -> o_dval at t+2 (empty FIFO, i_drdy=1).
//  Throughput: 1 word/cycle sustained with continuous i_dval and i_drdy.
//  Capacity: WORDWD+2 words (RF plus skid). o_count = rf_cnt + inflight + skid_cnt, max WORDWD+2.
//  Order: strict FIFO across wrap-around.
//  i_clear: next edge resets pointers and counters and discards in-flight read data.
//   o_dval=0 and o_count=0 from the next cycle.
//   Clear wins over a simultaneous push (word dropped, RF not written) and over a pop
//   (the consumer still sees the handshake).
//  Reset mid-operation: all contents lost. No RF access occurs while i_rst is high; RF contents are don't-care.
//  Empty with simultaneous push: no bypass; minimum latency stays 2 cycles.
// TESTING
//  1. Empty FIFO, push 0x0A5 at cycle 0, i_drdy=1 -> o_rf_write c0, o_rf_read addr 0 c1, o_dval with 0x0A5 c2, o_count back to 0 c3.
//  2. i_drdy=0, i_dval=1 continuous -> exactly 14 words accepted (WORDWD=12); o_drdy=0 and o_count=14 thereafter.
//     Then i_drdy=1 -> 14 words out in order, o_drdy returns 1 one cycle after the first RF read.
//  3. 100 words, i_dval=i_drdy=1 continuous -> one output per cycle after 2-cycle latency, no bubbles, order preserved.
//     Addresses cycle 0..11,0,...
//  4. 300 words with random i_dval/i_drdy (50%) -> scoreboard matches; no write to a slot whose read is not yet issued;
//     o_count never exceeds 14.
//  5. 8 words buffered, one read in flight, i_clear together with a push -> next cycle o_dval=0 and o_count=0.
//     The next pushed word 0x123 is written at addr 0 and is the only word output.
//  6. Assert i_rst mid-stream with 5 words held -> outputs take reset values immediately.
//     After release, a push of 0x7FF emerges at latency 2 from addr 0.

Source files
------------

// File: rtl/rf_2p_fifo_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// rf_2p_fifo_ctrl_if : stream, flush, status and RF-port bundle.  Rev 1.0
// ------------------------------------------------------------------------
interface rf_2p_fifo_ctrl_if #(
  parameter int DWD  = 16,
  parameter int SIZE = 1,
  parameter int AWD  = 4,
  parameter int CWD  = 4
);
  logic                     i_clear;
  logic                     i_dval;
  logic                     o_drdy;
  logic [SIZE-1:0][DWD-1:0] i_data;
  logic                     o_dval;
  logic                     i_drdy;
  logic [SIZE-1:0][DWD-1:0] o_data;
  logic [CWD-1:0]           o_count;
  logic                     o_rf_read;
  logic                     o_rf_write;
  logic [AWD-1:0]           o_rf_raddr;
  logic [AWD-1:0]           o_rf_waddr;
  logic [SIZE-1:0][DWD-1:0] o_rf_wdata;
  logic [SIZE-1:0][DWD-1:0] i_rf_rdata;

  modport slave (
    input  i_clear, i_dval, i_data, i_drdy, i_rf_rdata,
    output o_drdy, o_dval, o_data, o_count,
           o_rf_read, o_rf_write, o_rf_raddr, o_rf_waddr, o_rf_wdata
  );

  modport master (
    output i_clear, i_dval, i_data, i_drdy, i_rf_rdata,
    input  o_drdy, o_dval, o_data, o_count,
           o_rf_read, o_rf_write, o_rf_raddr, o_rf_waddr, o_rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rf_2p_fifo_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// rf_2p_fifo_ctrl : valid/ready FIFO over an RF_2P macro, 2-entry read skid.  Rev 1.0
// ------------------------------------------------------------------------
module rf_2p_fifo_ctrl #(
  parameter int WORDWD = 12,
  parameter int DWD    = 16,
  parameter int AWD    = $clog2(WORDWD),
  parameter int SIZE   = 1,
  parameter int CWD    = $clog2(WORDWD + 3)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rf_2p_fifo_ctrl_if.slave       bus
);
  typedef logic [SIZE-1:0][DWD-1:0] word_t;

  localparam logic [AWD-1:0] c_last_addr = AWD'(WORDWD - 1);
  localparam logic [CWD-1:0] c_full      = CWD'(WORDWD);

  logic [AWD-1:0] wptr_q, wptr_d;
  logic [AWD-1:0] rptr_q, rptr_d;
  logic [CWD-1:0] rf_cnt_q, rf_cnt_d;
  logic           inflight_q, inflight_d;
  logic [1:0]     skid_cnt_q, skid_cnt_d;
  word_t          skid0_q, skid0_d;
  word_t          skid1_q, skid1_d;

  logic           w_drdy;
  logic           w_dval;
  logic           w_push;
  logic           w_pop;
  logic           w_write;
  logic           w_read;
  logic [2:0]     w_buf_after;
  word_t          w_head;

  // The word arriving from the RF is visible in its arrival cycle, which keeps latency at 2.
  assign w_drdy      = (rf_cnt_q != c_full);
  assign w_dval      = (skid_cnt_q != 2'd0) | inflight_q;
  assign w_head      = (skid_cnt_q != 2'd0) ? skid0_q : (inflight_q ? bus.i_rf_rdata : '0);
  assign w_push      = bus.i_dval & w_drdy;
  assign w_pop       = w_dval & bus.i_drdy;
  assign w_write     = w_push & ~bus.i_clear & ~i_rst;
  assign w_buf_after = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_read      = (rf_cnt_q != '0) & (w_buf_after < 3'd2) & ~bus.i_clear & ~i_rst;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rf_cnt_d   = rf_cnt_q;
    inflight_d = w_read;
    skid_cnt_d = skid_cnt_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    if (bus.i_clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      rf_cnt_d   = '0;
      inflight_d = 1'b0;
      skid_cnt_d = 2'd0;
    end else begin
      if (w_write) begin
        wptr_d = (wptr_q == c_last_addr) ? '0 : wptr_q + AWD'(1);
      end
      if (w_read) begin
        rptr_d = (rptr_q == c_last_addr) ? '0 : rptr_q + AWD'(1);
      end
      rf_cnt_d   = rf_cnt_q + CWD'(w_write) - CWD'(w_read);
      skid_cnt_d = w_buf_after[1:0];
      if (skid_cnt_q == 2'd0) begin
        if (inflight_q) begin
          skid0_d = bus.i_rf_rdata;
        end
      end else begin
        if (w_pop) begin
          skid0_d = skid1_q;
        end
        // Arriving data lands behind whatever survives the pop.
        if (inflight_q) begin
          if (w_pop && (skid_cnt_q == 2'd1)) begin
            skid0_d = bus.i_rf_rdata;
          end else begin
            skid1_d = bus.i_rf_rdata;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rf_cnt_q   <= '0;
      inflight_q <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rf_cnt_q   <= rf_cnt_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  assign bus.o_drdy     = w_drdy;
  assign bus.o_dval     = w_dval;
  assign bus.o_data     = w_head;
  assign bus.o_count    = rf_cnt_q + CWD'(inflight_q) + CWD'(skid_cnt_q);
  assign bus.o_rf_read  = w_read;
  assign bus.o_rf_write = w_write;
  assign bus.o_rf_raddr = rptr_q;
  assign bus.o_rf_waddr = wptr_q;
  assign bus.o_rf_wdata = bus.i_data;
endmodule
`default_nettype wire
